// File: rtl/archel_pkg.sv
// Shared architecture constants: instruction width, field positions and opcodes.
// Imported by the fetch, decode and register-file stages.
package archel_pkg;

    localparam int INST_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_SWI  = 4'b1010;
    localparam logic [3:0] OP_BEZ  = 4'b1100;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and fetch FSM.
// Fetches one word over req/ack, presents it over valid/ready, redirects on taken branches.
module fetch_unit
    import archel_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [3:0]        inst_opcode,
    output logic [3:0]        inst_rd,
    output logic [3:0]        inst_rs,
    output logic [3:0]        inst_rt,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_abandon_addr;
    logic [ADDR_W-1:0] w_abandon_next;
    logic [INST_W-1:0] r_inst;
    logic [INST_W-1:0] w_inst_next;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [ADDR_W-1:0] w_inst_pc_next;
    // Low for the cycle after reset so no request is issued until rst has been low for an edge.
    logic              r_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= FETCH;
            r_pc           <= RESET_PC;
            r_abandon_addr <= '0;
            r_inst         <= '0;
            r_inst_pc      <= '0;
            r_run          <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_abandon_addr <= w_abandon_next;
            r_inst         <= w_inst_next;
            r_inst_pc      <= w_inst_pc_next;
            r_run          <= 1'b1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_abandon_next = r_abandon_addr;
        w_inst_next    = r_inst;
        w_inst_pc_next = r_inst_pc;

        imem_req    = 1'b0;
        imem_addr   = r_pc;
        inst_valid  = 1'b0;
        inst_opcode = r_inst[OPC_MSB:OPC_LSB];
        inst_rd     = r_inst[RD_MSB:RD_LSB];
        inst_rs     = r_inst[RS_MSB:RS_LSB];
        inst_rt     = r_inst[RT_MSB:RT_LSB];
        inst_pc     = r_inst_pc;

        if (r_run) begin
            case (r_state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (br_taken) begin
                        w_pc_next = br_target;
                        // Without an ack the request stays on the bus, so remember what it was.
                        if (!imem_ack) begin
                            w_abandon_next = r_pc;
                            w_state_next   = DISCARD;
                        end
                    end else if (imem_ack) begin
                        w_inst_next    = imem_rdata;
                        w_inst_pc_next = r_pc;
                        w_pc_next      = r_pc + ADDR_W'(1);
                        w_state_next   = HOLD;
                    end
                end
                HOLD: begin
                    inst_valid = 1'b1;
                    if (br_taken) begin
                        w_pc_next    = br_target;
                        w_state_next = FETCH;
                    end else if (inst_ready) begin
                        w_state_next = FETCH;
                    end
                end
                DISCARD: begin
                    imem_req  = 1'b1;
                    imem_addr = r_abandon_addr;
                    if (br_taken) begin
                        w_pc_next = br_target;
                    end
                    if (imem_ack) begin
                        w_state_next = FETCH;
                    end
                end
                default: begin
                    w_state_next = FETCH;
                end
            endcase
        end
    end

endmodule
